vga_capture: RTL and testbench
==============================

// Module: vga_capture
// PURPOSE
//  Receive end of our VGA pixel interface: samples a 24-bit pixel stream with Hsync/Vsync/blank
//  (as our VGA timing generator drives it), measures line/frame timing, locks to 800x525,
//  and writes active 640x480 pixels into a VRAM-style write port (X, Y, data, strobe).
//  Sits between an external/looped-back video source and the frame-buffer VRAM.
// PARAMETERS
//  H_ACTIVE     640  visible pixels per line
//  V_ACTIVE     480  visible lines per frame
//  H_TOTAL      800  pixel periods per line (Hsync edge to Hsync edge)
//  V_TOTAL      525  lines per frame (Vsync edge to Vsync edge)
//  LOCK_FRAMES  2    consecutive matching frames required for lock (1..15)
//  SYNC_ACT_LOW 1    1: Hsync/Vsync asserted low; 0: asserted high
// PORTS
//  Clk        in   1   system clock; all logic posedge Clk
//  Rst        in   1   synchronous reset, active-high
//  PixEn      in   1   pixel-clock enable, one Clk cycle per pixel period
//  Hsync      in   1   horizontal sync
//  Vsync      in   1   vertical sync
//  VGA_blank  in   1   active-low blank: 1 = visible pixel
//  VGA_Pixel  in   24  RGB888 {R,G,B}
//  WrEn       out  1   one-Clk write strobe
//  WrX        out  11  active pixel column 0..H_ACTIVE-1
//  WrY        out  11  active line 0..V_ACTIVE-1
//  WrData     out  24  pixel data (16 with VGA_CAP_RGB565_EN)
//  FrameStart out  1   one-Clk pulse: captured frame begins
//  FrameDone  out  1   one-Clk pulse: captured frame ended
//  Locked     out  1   timing lock status
//  OvfErr     out  1   sticky: active pixel/line beyond H_ACTIVE/V_ACTIVE seen while locked
// BEHAVIOUR
//  - Reset: all outputs 0, counters 0, state IDLE; OvfErr cleared only by Rst.
//  - Inputs sampled only on PixEn cycles into one register stage; edges = inactive->asserted
//    transition between consecutive samples. Non-PixEn cycles: no state change, no strobes.
//  - HCnt counts PixEn samples, cleared at Hsync edge; VCnt counts Hsync edges, cleared at Vsync edge.
//  - Active X/Y: X increments per visible sample, cleared at Hsync edge; Y increments at Hsync
//    edge if previous line had >=1 visible sample, cleared at Vsync edge.
//  - Line check at each Hsync edge: HCnt==H_TOTAL else mismatch; frame check at Vsync edge:
//    VCnt==V_TOTAL else mismatch. Hsync and Vsync edges in same sample: Vsync processed after line.
//  - FSM: IDLE -> MEASURE on first Vsync edge (first partial frame never counted).
//    MEASURE: at Vsync edge, clean frame increments MatchCnt, mismatch clears it;
//    MatchCnt==LOCK_FRAMES -> CAPTURE, Locked=1, FrameStart pulses same cycle.
//    CAPTURE: any mismatch -> MEASURE, Locked=0, MatchCnt=0, no further writes that frame.
//    CAPTURE at clean Vsync edge: FrameDone then FrameStart in the same cycle.
//  - Writes only in CAPTURE: visible sample at PixEn cycle n -> WrEn=1 in cycle n+1 (1 Clk),
//    WrX/WrY/WrData held until next strobe. X>=H_ACTIVE or Y>=V_ACTIVE: no write, OvfErr=1.
//  - Rst mid-frame: IDLE, Locked=0; lock reacquired after 1 partial + LOCK_FRAMES frames.
//  - Counters 11 bit, saturate at 2047 (forces mismatch, never wraps to a false match).
// CONFIGURATION
//  VGA_CAP_RGB565_EN defined: WrData 16 bits = {R[7:3],G[7:2],B[7:3]}, truncation, no rounding.
//  Not defined: WrData 24 bits, VGA_Pixel passed unchanged. Timing identical either way.
// STRUCTURE
//  Package vga_cap_pkg: state enum {IDLE,MEASURE,CAPTURE}; 640/480/800/525 timing constants;
//  counter width constant (11); pixel width typedefs for both data formats.
//  Sub-module vga_sync_sample: PixEn-qualified input register, polarity normalise, edge pulses.
// TESTING
//  1 Ideal 800x525 source, PixEn every 2nd Clk, incrementing pattern -> Locked after 1 partial+2
//    frames; 307200 writes/frame; pixel (639,479) data correct; WrEn 1 Clk after sample.
//  2 Lock then one line of 799 pixels -> Locked=0 at that Hsync edge, writes stop,
//    relock after 2 clean frames; no FrameDone for broken frame.
//  3 Locked, frame of 524 lines -> mismatch at Vsync edge, Locked=0, MatchCnt=0.
//  4 Blank visible for 641 pixels on line 10 -> 640 writes, OvfErr=1 and stays 1 until Rst.
//  5 Rst pulse at line 200 of a captured frame -> outputs 0 next cycle, IDLE, no writes
//    until relock; SYNC_ACT_LOW=0 run with inverted syncs -> same results as scenario 1.
//  6 VGA_CAP_RGB565_EN, pixel 24'hFF8040 -> WrData 16'hFC08.

Source files
------------

// File: rtl/vga_capture_pkg.sv
// Shared types and constants for the VGA capture block.
// Optional feature macro: VGA_CAP_RGB565_EN (16-bit RGB565 write data instead of RGB888).
package vga_cap_pkg;

  typedef enum logic [1:0] {IDLE, MEASURE, CAPTURE} cap_state_e;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned H_TOTAL_DEF  = 800;
  localparam int unsigned V_TOTAL_DEF  = 525;
  localparam int unsigned CNT_W        = 11;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [23:0]      pix24_t;
  typedef logic [15:0]      pix16_t;

`ifdef VGA_CAP_RGB565_EN
  typedef pix16_t wr_pix_t;
`else
  typedef pix24_t wr_pix_t;
`endif

  // Saturating increment: a runaway count parks at all-ones and never aliases a valid total.
  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == '1) ? c : c + cnt_t'(1);
  endfunction

  function automatic wr_pix_t pix_fmt(input pix24_t p);
`ifdef VGA_CAP_RGB565_EN
    return {p[23:19], p[15:10], p[7:3]};
`else
    return p;
`endif
  endfunction

endpackage

// File: rtl/vga_capture_if.sv
// VRAM-style write port driven by vga_capture.
interface vga_capture_if;
  import vga_cap_pkg::*;

  logic    WrEn;
  cnt_t    WrX;
  cnt_t    WrY;
  wr_pix_t WrData;

  modport master (output WrEn, WrX, WrY, WrData);
  modport slave  (input  WrEn, WrX, WrY, WrData);
endinterface

// File: rtl/vga_capture_sync_sample.sv
// PixEn-qualified sync sampling: polarity normalisation and inactive->asserted edge pulses.
module vga_sync_sample #(
  parameter bit SYNC_ACT_LOW = 1'b1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic PixEn,
  input  logic Hsync,
  input  logic Vsync,
  input  logic VGA_blank,
  output logic hs_edge,
  output logic vs_edge,
  output logic vis
);
  logic hs_n, vs_n, hs_q, vs_q;

  assign hs_n = SYNC_ACT_LOW ? ~Hsync : Hsync;
  assign vs_n = SYNC_ACT_LOW ? ~Vsync : Vsync;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
    end else if (PixEn) begin
      hs_q <= hs_n;
      vs_q <= vs_n;
    end
  end

  assign hs_edge = PixEn & hs_n & ~hs_q;
  assign vs_edge = PixEn & vs_n & ~vs_q;
  assign vis     = PixEn & VGA_blank;
endmodule

// File: rtl/vga_capture.sv
// VGA receive side: measures line/frame timing, locks, writes active pixels to VRAM port.
// Optional feature macro: VGA_CAP_RGB565_EN (see vga_cap_pkg).
module vga_capture
  import vga_cap_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
  parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL      = V_TOTAL_DEF,
  parameter int unsigned LOCK_FRAMES  = 2,
  parameter bit          SYNC_ACT_LOW = 1'b1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          PixEn,
  input  logic          Hsync,
  input  logic          Vsync,
  input  logic          VGA_blank,
  input  pix24_t        VGA_Pixel,
  vga_capture_if.master wr,
  output logic          FrameStart,
  output logic          FrameDone,
  output logic          Locked,
  output logic          OvfErr
);
  cap_state_e state;
  cnt_t       hcnt, vcnt, xcnt, ycnt;
  cnt_t       vcnt_nx, x_cur, y_cur;
  logic [3:0] match_cnt, match_nx;
  logic       hvld, line_vis, frame_bad;
  logic       hs_edge, vs_edge, vis;
  logic       line_bad, frame_clean, in_range;

  vga_sync_sample #(.SYNC_ACT_LOW(SYNC_ACT_LOW)) u_sample (
    .Clk      (Clk),
    .Rst      (Rst),
    .PixEn    (PixEn),
    .Hsync    (Hsync),
    .Vsync    (Vsync),
    .VGA_blank(VGA_blank),
    .hs_edge  (hs_edge),
    .vs_edge  (vs_edge),
    .vis      (vis)
  );

  // Line check precedes frame check so a coincident Hsync edge belongs to the ending frame.
  always_comb begin
    line_bad    = hs_edge & hvld & (hcnt != cnt_t'(H_TOTAL - 1));
    vcnt_nx     = hs_edge ? sat_inc(vcnt) : vcnt;
    frame_clean = ~frame_bad & ~line_bad & (vcnt_nx == cnt_t'(V_TOTAL));
    x_cur       = hs_edge ? '0 : xcnt;
    y_cur       = vs_edge ? '0 : ((hs_edge && line_vis) ? sat_inc(ycnt) : ycnt);
    in_range    = (x_cur < cnt_t'(H_ACTIVE)) && (y_cur < cnt_t'(V_ACTIVE));
    match_nx    = match_cnt + 4'd1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      hcnt       <= '0;
      vcnt       <= '0;
      xcnt       <= '0;
      ycnt       <= '0;
      match_cnt  <= '0;
      hvld       <= 1'b0;
      line_vis   <= 1'b0;
      frame_bad  <= 1'b0;
      wr.WrEn    <= 1'b0;
      wr.WrX     <= '0;
      wr.WrY     <= '0;
      wr.WrData  <= '0;
      FrameStart <= 1'b0;
      FrameDone  <= 1'b0;
      Locked     <= 1'b0;
      OvfErr     <= 1'b0;
    end else begin
      wr.WrEn    <= 1'b0;
      FrameStart <= 1'b0;
      FrameDone  <= 1'b0;
      if (PixEn) begin
        hcnt     <= hs_edge ? '0 : sat_inc(hcnt);
        vcnt     <= vs_edge ? '0 : vcnt_nx;
        xcnt     <= vis ? sat_inc(x_cur) : x_cur;
        ycnt     <= y_cur;
        line_vis <= vis | (line_vis & ~hs_edge);
        if (hs_edge)  hvld <= 1'b1;
        // A bad line taints the rest of its frame; a Vsync edge starts the next one clean.
        if (vs_edge)       frame_bad <= 1'b0;
        else if (line_bad) frame_bad <= 1'b1;

        case (state)
          IDLE: begin
            if (vs_edge) begin
              state     <= MEASURE;
              match_cnt <= '0;
            end
          end
          MEASURE: begin
            if (vs_edge) begin
              if (frame_clean) begin
                match_cnt <= match_nx;
                if (match_nx == 4'(LOCK_FRAMES)) begin
                  state      <= CAPTURE;
                  Locked     <= 1'b1;
                  FrameStart <= 1'b1;
                end
              end else begin
                match_cnt <= '0;
              end
            end
          end
          CAPTURE: begin
            if (line_bad || (vs_edge && !frame_clean)) begin
              state     <= MEASURE;
              Locked    <= 1'b0;
              match_cnt <= '0;
            end else begin
              if (vs_edge) begin
                FrameDone  <= 1'b1;
                FrameStart <= 1'b1;
              end
              if (vis) begin
                if (in_range) begin
                  wr.WrEn   <= 1'b1;
                  wr.WrX    <= x_cur;
                  wr.WrY    <= y_cur;
                  wr.WrData <= pix_fmt(VGA_Pixel);
                end else begin
                  OvfErr <= 1'b1;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vga_capture.sv
// Frame-level vector bench for vga_capture on a reduced 6x4 / 10x7 timing, both sync polarities.
module tb_vga_capture;
  localparam int unsigned HA = 6;
  localparam int unsigned VA = 4;
  localparam int unsigned HT = 10;
  localparam int unsigned VT = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Rst, PixEn, hs, vs, blank;
  logic [23:0] pix;
  logic [1:0]  fs, fd, lk, ovf;
  logic        wen [2];
  logic [10:0] wx  [2];
  logic [10:0] wy  [2];
  logic [23:0] wd  [2];

  int total = 0;
  int bad   = 0;
  int nwr [2], nfs [2], nfd [2], idle_err [2];

  vga_capture_if vif0 ();
  vga_capture_if vif1 ();

  vga_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT),
                .LOCK_FRAMES(2), .SYNC_ACT_LOW(1'b1)) dut0 (
    .Clk(clk), .Rst(Rst), .PixEn(PixEn), .Hsync(~hs), .Vsync(~vs),
    .VGA_blank(blank), .VGA_Pixel(pix), .wr(vif0.master),
    .FrameStart(fs[0]), .FrameDone(fd[0]), .Locked(lk[0]), .OvfErr(ovf[0]));

  vga_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT),
                .LOCK_FRAMES(2), .SYNC_ACT_LOW(1'b0)) dut1 (
    .Clk(clk), .Rst(Rst), .PixEn(PixEn), .Hsync(hs), .Vsync(vs),
    .VGA_blank(blank), .VGA_Pixel(pix), .wr(vif1.master),
    .FrameStart(fs[1]), .FrameDone(fd[1]), .Locked(lk[1]), .OvfErr(ovf[1]));

  assign wen[0] = vif0.WrEn;
  assign wx[0]  = vif0.WrX;
  assign wy[0]  = vif0.WrY;
  assign wd[0]  = 24'(vif0.WrData);
  assign wen[1] = vif1.WrEn;
  assign wx[1]  = vif1.WrX;
  assign wy[1]  = vif1.WrY;
  assign wd[1]  = 24'(vif1.WrData);

  typedef struct {
    int start_line;
    int vlines;
    int bad_line;
    int ovf_line;
    int rst_line;
    int exp_wr;
    int exp_fs;
    int exp_fd;
    bit exp_lk;
    bit exp_ovf;
  } vec_t;

  vec_t tbl [19];

  function automatic logic [23:0] exp_data(input logic [23:0] p);
`ifdef VGA_CAP_RGB565_EN
    return {8'h00, p[23:19], p[15:10], p[7:3]};
`else
    return p;
`endif
  endfunction

  task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string nm);
    for (int d = 0; d < 2; d++)
      check($sformatf("%s d%0d", nm, d),
            64'({lk[d], ovf[d], fs[d], fd[d], wen[d], wx[d], wy[d], wd[d]}), 64'd0);
  endtask

  task automatic send_sample(input logic h_a, input logic v_a, input logic vis,
                             input logic [23:0] p, input logic legal, input int ex, input int ey);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      if (wen[d] || fs[d] || fd[d]) idle_err[d]++;
    hs = h_a; vs = v_a; blank = vis; pix = p; PixEn = 1'b1;
    @(negedge clk);
    PixEn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (fs[d]) nfs[d]++;
      if (fd[d]) nfd[d]++;
      if (wen[d]) begin
        nwr[d]++;
        check($sformatf("wr_xyd d%0d", d), 64'({legal, wx[d], wy[d], wd[d]}),
              64'({1'b1, 11'(ex), 11'(ey), exp_data(p)}));
      end
    end
  endtask

  // One generated frame starts at its Vsync edge: Vsync on lines 0-1, visible lines 2-5,
  // Hsync asserted at h 7..8 of every line.
  task automatic send_frame(input int fr, input vec_t v);
    int hl, nvis;
    logic [23:0] p;
    logic vis;
    for (int l = v.start_line; l < v.vlines; l++) begin
      hl   = (l == v.bad_line) ? 9 : 10;
      nvis = (l == v.ovf_line) ? 7 : 6;
      for (int h = 0; h < hl; h++) begin
        if (l == v.rst_line && h == 2) begin
          @(negedge clk);
          Rst = 1'b1;
          @(negedge clk);
          Rst = 1'b0;
          check_zero_outputs($sformatf("f%0d rst_mid", fr));
        end
        vis = (l >= 2) && (l <= 5) && (h < nvis);
        p   = (l == 2 && h == 0) ? 24'hFF8040 : {8'(fr), 8'(l), 8'(h)};
        send_sample(h == 7 || h == 8, l < 2, vis, p, vis && (h < int'(HA)), h, l - 2);
        if (v.bad_line >= 0 && l == v.bad_line + 1 && h == 7)
          for (int d = 0; d < 2; d++)
            check($sformatf("f%0d d%0d unlock_at_edge", fr, d), 64'(lk[d]), 64'd0);
      end
    end
  endtask

  initial begin
    //          start vl  bad ovf rst  wr fs fd lk ovf
    tbl[0]  = '{4, 7, -1, -1, -1,  0, 0, 0, 0, 0};
    tbl[1]  = '{0, 7, -1, -1, -1,  0, 0, 0, 0, 0};
    tbl[2]  = '{0, 7, -1, -1, -1,  0, 0, 0, 0, 0};
    tbl[3]  = '{0, 7, -1, -1, -1, 24, 1, 0, 1, 0};
    tbl[4]  = '{0, 7, -1, -1, -1, 24, 1, 1, 1, 0};
    tbl[5]  = '{0, 7,  3, -1, -1, 18, 1, 1, 0, 0};
    tbl[6]  = '{0, 7, -1, -1, -1,  0, 0, 0, 0, 0};
    tbl[7]  = '{0, 7, -1, -1, -1,  0, 0, 0, 0, 0};
    tbl[8]  = '{0, 7, -1, -1, -1, 24, 1, 0, 1, 0};
    tbl[9]  = '{0, 6, -1, -1, -1, 24, 1, 1, 1, 0};
    tbl[10] = '{0, 7, -1, -1, -1,  0, 0, 0, 0, 0};
    tbl[11] = '{0, 7, -1, -1, -1,  0, 0, 0, 0, 0};
    tbl[12] = '{0, 7, -1,  3, -1, 24, 1, 0, 1, 1};
    tbl[13] = '{0, 7, -1, -1, -1, 24, 1, 1, 1, 1};
    tbl[14] = '{0, 7, -1, -1,  3,  8, 1, 1, 0, 0};
    tbl[15] = '{0, 7, -1, -1, -1,  0, 0, 0, 0, 0};
    tbl[16] = '{0, 7, -1, -1, -1,  0, 0, 0, 0, 0};
    tbl[17] = '{0, 7, -1, -1, -1, 24, 1, 0, 1, 0};
    tbl[18] = '{0, 7, -1, -1, -1, 24, 1, 1, 1, 0};

    Rst = 1'b1; PixEn = 1'b0; hs = 1'b0; vs = 1'b0; blank = 1'b0; pix = '0;
    repeat (3) @(negedge clk);
    Rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("reset_state");

    for (int i = 0; i < 19; i++) begin
      for (int d = 0; d < 2; d++) begin
        nwr[d] = 0; nfs[d] = 0; nfd[d] = 0; idle_err[d] = 0;
      end
      send_frame(i, tbl[i]);
      for (int d = 0; d < 2; d++) begin
        check($sformatf("f%0d d%0d writes", i, d), 64'(nwr[d]), 64'(tbl[i].exp_wr));
        check($sformatf("f%0d d%0d frame_start", i, d), 64'(nfs[d]), 64'(tbl[i].exp_fs));
        check($sformatf("f%0d d%0d frame_done", i, d), 64'(nfd[d]), 64'(tbl[i].exp_fd));
        check($sformatf("f%0d d%0d locked", i, d), 64'(lk[d]), 64'(tbl[i].exp_lk));
        check($sformatf("f%0d d%0d ovf", i, d), 64'(ovf[d]), 64'(tbl[i].exp_ovf));
        check($sformatf("f%0d d%0d idle_strobe", i, d), 64'(idle_err[d]), 64'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
